// File: rtl/video_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// video_pattern_gen_if
// Bundles the control inputs and video outputs of video_pattern_gen.
//   enable     : run request, sampled at frame boundaries
//   box_x/y    : rectangle top-left corner (column, line)
//   box_w/h    : rectangle size; either one 0 means no rectangle
//   h_sync     : high while an active pixel is presented
//   v_sync     : high from the first active pixel through the last line's H blank
//   pixel_out  : 24-bit RGB pixel
//   pixel_x/y  : current pixel column / line
//   frame_done : one-cycle pulse on the first V-blank cycle
// Modports: master = the generator, slave = the control/consumer side.
// -----------------------------------------------------------------------------
interface video_pattern_gen_if #(
  parameter int CW = 16
);
  logic          enable;
  logic [CW-1:0] box_x;
  logic [CW-1:0] box_y;
  logic [CW-1:0] box_w;
  logic [CW-1:0] box_h;
  logic          h_sync;
  logic          v_sync;
  logic [23:0]   pixel_out;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          frame_done;

  modport master (
    input  enable, box_x, box_y, box_w, box_h,
    output h_sync, v_sync, pixel_out, pixel_x, pixel_y, frame_done
  );

  modport slave (
    output enable, box_x, box_y, box_w, box_h,
    input  h_sync, v_sync, pixel_out, pixel_x, pixel_y, frame_done
  );
endinterface

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
// Synthetic video source: a flat background with one programmable solid
// rectangle, framed by active-high line/frame valids. Feeds the object
// tracker for self-test in place of a camera front end.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset (wins over everything)
//   vid : video_pattern_gen_if.master (enable, box_*, h_sync, v_sync,
//         pixel_out, pixel_x, pixel_y, frame_done)
// Every output is a register; the next-cycle state and counters are computed
// combinationally and the outputs are decoded from those next values so the
// registered outputs describe the cycle they are presented in.
// -----------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int          H_ACTIVE = 10,
  parameter int          V_ACTIVE = 10,
  parameter int          H_BLANK  = 2,
  parameter int          V_BLANK  = 10,
  parameter int          CW       = 16,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h101010
) (
  input  logic                clk,
  input  logic                rst,
  video_pattern_gen_if.master vid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HBLANK = 2'd2;
  localparam logic [1:0] S_VBLANK = 2'd3;

  // Blank counter is shared by H and V blank, so it is sized for the longer one.
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BCW  = $clog2(BMAX + 1);

  localparam logic [CW-1:0]  H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]  V_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [BCW-1:0] HB_LAST = BCW'(H_BLANK - 1);
  localparam logic [BCW-1:0] VB_LAST = BCW'(V_BLANK - 1);

  // State, counters and the per-frame copy of the rectangle.
  logic [1:0]     r_state;
  logic           r_start;   // enable seen in IDLE; ACTIVE begins next cycle
  logic [CW-1:0]  r_hc;
  logic [CW-1:0]  r_vc;
  logic [BCW-1:0] r_bc;
  logic [CW-1:0]  r_box_x, r_box_y, r_box_w, r_box_h;

  // Registered outputs.
  logic           r_h_sync, r_v_sync, r_frame_done;
  logic [23:0]    r_pixel;
  logic [CW-1:0]  r_pixel_x, r_pixel_y;

  // Next-cycle values.
  logic [1:0]     w_state_nx;
  logic           w_start_nx;
  logic [CW-1:0]  w_hc_nx, w_vc_nx;
  logic [BCW-1:0] w_bc_nx;
  logic [CW-1:0]  w_box_x_nx, w_box_y_nx, w_box_w_nx, w_box_h_nx;
  logic           w_latch_box;

  logic [CW:0]    w_x_end, w_y_end;
  logic           w_in_box;
  logic           w_h_sync_nx, w_v_sync_nx, w_frame_done_nx;
  logic [23:0]    w_pixel_nx;
  logic [CW-1:0]  w_pixel_x_nx, w_pixel_y_nx;

  // ---------------------------------------------------------------------------
  // Sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nx  = r_state;
    w_start_nx  = r_start;
    w_hc_nx     = r_hc;
    w_vc_nx     = r_vc;
    w_bc_nx     = r_bc;
    w_latch_box = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_state_nx = S_ACTIVE;
          w_start_nx = 1'b0;
          w_hc_nx    = '0;
          w_vc_nx    = '0;
        end else if (vid.enable) begin
          w_start_nx  = 1'b1;
          w_latch_box = 1'b1;
        end
      end

      S_ACTIVE: begin
        if (r_hc == H_LAST) begin
          w_state_nx = S_HBLANK;
          w_bc_nx    = '0;
        end else begin
          w_hc_nx = r_hc + 1'b1;
        end
      end

      S_HBLANK: begin
        if (r_bc == HB_LAST) begin
          if (r_vc == V_LAST) begin
            w_state_nx = S_VBLANK;
            w_bc_nx    = '0;
          end else begin
            w_state_nx = S_ACTIVE;
            w_hc_nx    = '0;
            w_vc_nx    = r_vc + 1'b1;
          end
        end else begin
          w_bc_nx = r_bc + 1'b1;
        end
      end

      default: begin // S_VBLANK
        if (r_bc == VB_LAST) begin
          w_hc_nx = '0;
          w_vc_nx = '0;
          if (vid.enable) begin
            // Back-to-back frame: new rectangle, no idle gap.
            w_state_nx  = S_ACTIVE;
            w_latch_box = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_bc_nx = r_bc + 1'b1;
        end
      end
    endcase

    w_box_x_nx = w_latch_box ? vid.box_x : r_box_x;
    w_box_y_nx = w_latch_box ? vid.box_y : r_box_y;
    w_box_w_nx = w_latch_box ? vid.box_w : r_box_w;
    w_box_h_nx = w_latch_box ? vid.box_h : r_box_h;
  end

  // ---------------------------------------------------------------------------
  // Output decode from next-cycle state. Bounds are one bit wider than the
  // coordinates so box_x+box_w cannot wrap; clipping at the frame edge falls
  // out of hc/vc never leaving the active area.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_x_end  = {1'b0, w_box_x_nx} + {1'b0, w_box_w_nx};
    w_y_end  = {1'b0, w_box_y_nx} + {1'b0, w_box_h_nx};
    w_in_box = (w_hc_nx >= w_box_x_nx) && ({1'b0, w_hc_nx} < w_x_end) &&
               (w_vc_nx >= w_box_y_nx) && ({1'b0, w_vc_nx} < w_y_end);

    w_h_sync_nx     = (w_state_nx == S_ACTIVE);
    w_v_sync_nx     = (w_state_nx == S_ACTIVE) || (w_state_nx == S_HBLANK);
    w_frame_done_nx = (w_state_nx == S_VBLANK) && (r_state != S_VBLANK);
    w_pixel_x_nx    = w_h_sync_nx ? w_hc_nx : '0;
    w_pixel_y_nx    = w_v_sync_nx ? w_vc_nx : '0;
    w_pixel_nx      = '0;
    if (w_h_sync_nx) begin
      w_pixel_nx = w_in_box ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_start      <= 1'b0;
      r_hc         <= '0;
      r_vc         <= '0;
      r_bc         <= '0;
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_box_w      <= '0;
      r_box_h      <= '0;
      r_h_sync     <= 1'b0;
      r_v_sync     <= 1'b0;
      r_frame_done <= 1'b0;
      r_pixel      <= '0;
      r_pixel_x    <= '0;
      r_pixel_y    <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_start      <= w_start_nx;
      r_hc         <= w_hc_nx;
      r_vc         <= w_vc_nx;
      r_bc         <= w_bc_nx;
      r_box_x      <= w_box_x_nx;
      r_box_y      <= w_box_y_nx;
      r_box_w      <= w_box_w_nx;
      r_box_h      <= w_box_h_nx;
      r_h_sync     <= w_h_sync_nx;
      r_v_sync     <= w_v_sync_nx;
      r_frame_done <= w_frame_done_nx;
      r_pixel      <= w_pixel_nx;
      r_pixel_x    <= w_pixel_x_nx;
      r_pixel_y    <= w_pixel_y_nx;
    end
  end

  assign vid.h_sync     = r_h_sync;
  assign vid.v_sync     = r_v_sync;
  assign vid.frame_done = r_frame_done;
  assign vid.pixel_out  = r_pixel;
  assign vid.pixel_x    = r_pixel_x;
  assign vid.pixel_y    = r_pixel_y;

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
// Directed bench for video_pattern_gen with default geometry (10x10 active,
// 2-cycle H blank, 10-cycle V blank, 130-cycle frame). A per-cycle reference
// derived from the frame timing checks syncs, coordinates and pixel colour;
// per-frame totals are checked against hand-computed counts.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

  localparam int CW    = 16;
  localparam int LINE  = 12;   // H_ACTIVE + H_BLANK
  localparam int FRAME = 130;  // 10*12 + 10

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;

  video_pattern_gen_if #(.CW(CW)) vif ();

  video_pattern_gen #(
    .H_ACTIVE(10), .V_ACTIVE(10), .H_BLANK(2), .V_BLANK(10), .CW(CW),
    .FG_COLOR(24'hFFFFFF), .BG_COLOR(24'h101010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_box(input int x, input int y, input int w, input int h);
    vif.box_x = CW'(x);
    vif.box_y = CW'(y);
    vif.box_w = CW'(w);
    vif.box_h = CW'(h);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sync"}, {61'd0, vif.h_sync, vif.v_sync, vif.frame_done}, 64'd0);
    check({tag, "_xy"},   {32'd0, vif.pixel_x, vif.pixel_y}, 64'd0);
    check({tag, "_pix"},  {40'd0, vif.pixel_out}, 64'd0);
  endtask

  // Observes n_cyc cycles of a frame whose first pixel appears at the next
  // edge. At t==chg_t the box inputs are changed; at t==drop_t enable drops.
  task automatic check_frame(input int bx, input int by, input int bw, input int bh,
                             input int n_cyc, input int exp_fg,
                             input int chg_t, input int nx, input int ny,
                             input int nw, input int nh, input int drop_t,
                             output int fd_at);
    int hs_n, vs_n, fg_n, bg_n, fd_n;
    hs_n = 0; vs_n = 0; fg_n = 0; bg_n = 0; fd_n = 0; fd_at = -1;
    for (int t = 0; t < n_cyc; t++) begin
      int line, pos;
      logic e_act, e_vs, e_fd, e_fg;
      logic [23:0] e_pix;
      logic [CW-1:0] e_x, e_y;
      step();
      line  = t / LINE;
      pos   = t % LINE;
      e_vs  = (t < 120);
      e_act = e_vs && (pos < 10);
      e_fd  = (t == 120);
      e_fg  = e_act && pos >= bx && pos < bx + bw && line >= by && line < by + bh;
      e_pix = !e_act ? 24'h0 : (e_fg ? 24'hFFFFFF : 24'h101010);
      e_x   = e_act ? CW'(pos) : '0;
      e_y   = e_vs ? CW'(line) : '0;
      check($sformatf("sync_t%0d", t), {61'd0, vif.h_sync, vif.v_sync, vif.frame_done},
            {61'd0, e_act, e_vs, e_fd});
      check($sformatf("xy_t%0d", t), {32'd0, vif.pixel_x, vif.pixel_y}, {32'd0, e_x, e_y});
      check($sformatf("pix_t%0d", t), {40'd0, vif.pixel_out}, {40'd0, e_pix});
      if (vif.h_sync) hs_n++;
      if (vif.v_sync) vs_n++;
      if (vif.h_sync && vif.pixel_out == 24'hFFFFFF) fg_n++;
      if (vif.h_sync && vif.pixel_out == 24'h101010) bg_n++;
      if (vif.frame_done) begin
        fd_n++;
        fd_at = cyc;
      end
      if (t == chg_t) set_box(nx, ny, nw, nh);
      if (t == drop_t) vif.enable = 1'b0;
    end
    if (n_cyc == FRAME) begin
      check("hs_count", 64'(hs_n), 64'd100);
      check("vs_count", 64'(vs_n), 64'd120);
      check("fg_count", 64'(fg_n), 64'(exp_fg));
      check("bg_count", 64'(bg_n), 64'(100 - exp_fg));
      check("fd_count", 64'(fd_n), 64'd1);
    end
  endtask

  initial begin
    int fd_a, fd_b, fd_c, fd_x;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst        = 1'b1;
    vif.enable = 1'b1;   // reset must win over enable
    set_box(3, 3, 3, 3);
    step();
    step();
    check_idle("reset");

    // Start: enable sampled at edge N, first pixel after edge N+1.
    rst = 1'b0;
    step();
    check_idle("start_lat");

    // A: box (3,3,3,3); box_x moves to 6 during line 4, next frame only.
    check_frame(3, 3, 3, 3, FRAME, 9, 4*LINE + 2, 6, 3, 3, 3, -1, fd_a);
    // B: box (6,3,3,3) -> FG at x 6..8.
    check_frame(6, 3, 3, 3, FRAME, 9, 30, 8, 8, 5, 5, -1, fd_b);
    // C: box (8,8,5,5) clipped -> 4 FG pixels.
    check_frame(8, 8, 5, 5, FRAME, 4, 30, 12, 0, 3, 3, -1, fd_c);
    check("fd_gap_ab", 64'(fd_b - fd_a), 64'd130);
    check("fd_gap_bc", 64'(fd_c - fd_b), 64'd130);
    // D: box wholly outside -> 0 FG.
    check_frame(12, 0, 3, 3, FRAME, 0, 30, 0, 0, 0, 3, -1, fd_x);
    // E: zero width -> 0 FG; enable drops at line 2, frame still completes.
    check_frame(0, 0, 0, 3, FRAME, 0, -1, 0, 0, 0, 0, 2*LINE, fd_x);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("idle_after_drop%0d", i));
    end

    // Mid-frame reset during line 5, then restart with enable held high.
    set_box(3, 3, 3, 3);
    vif.enable = 1'b1;
    step();
    check_idle("start_lat2");
    check_frame(3, 3, 3, 3, 5*LINE + 3, 9, -1, 0, 0, 0, 0, -1, fd_x);
    rst = 1'b1;
    step();
    check_idle("mid_rst");
    rst = 1'b0;
    step();
    check_idle("rst_restart_lat");
    check_frame(3, 3, 3, 3, FRAME, 9, -1, 0, 0, 0, 0, 0, fd_x);
    step();
    check_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

- Synthetic video source that drives the object tracker's input stream.
- Outputs the active-high line and frame valids (`h_sync`, `v_sync`) and 24-bit RGB pixels.
- Paints a runtime-programmable solid rectangle over a flat background.
- Sits in front of `object_tracker_top`, for on-chip self-test and bench stimulus in place of a camera front end.

## Interface
- `H_ACTIVE`, 10: active pixels per line (≥1)
- `V_ACTIVE`, 10: active lines per frame (≥1)
- `H_BLANK`, 2: blanking cycles after every active line (≥1)
- `V_BLANK`, 10: blanking cycles after the last line's H blank (≥1)
- `CW`, 16: coordinate/size port width (must hold H_ACTIVE and V_ACTIVE)
- `FG_COLOR`, 24'hFFFFFF: pixel value inside the rectangle
- `BG_COLOR`, 24'h101010: pixel value outside the rectangle, active region only

Ports:
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: run request, sampled at frame boundaries
- `box_x` in CW: rectangle left column
- `box_y` in CW: rectangle top line
- `box_w` in CW: rectangle width in pixels; 0 = no rectangle
- `box_h` in CW: rectangle height in lines; 0 = no rectangle
- `h_sync` out 1: high while an active pixel is presented
- `v_sync` out 1: high from the first active pixel through the last line's H blank
- `pixel_out` out 24: RGB pixel
- `pixel_x` out CW: column of the current active pixel, else 0
- `pixel_y` out CW: line of the current frame, else 0
- `frame_done` out 1: one-cycle pulse on the first V-blank cycle

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK. Horizontal counter `hc` and line counter `vc`.
- All outputs are registers and reflect the state/counters of the current cycle.
- IDLE: all outputs 0.
  - `enable`=1 sampled → latch `box_*` → next cycle is ACTIVE, x=0, y=0.
- ACTIVE: `h_sync`=1, `v_sync`=1, `pixel_x`=hc, `pixel_y`=vc.
  - `pixel_out` = FG_COLOR when box_x ≤ hc < box_x+box_w and box_y ≤ vc < box_y+box_h, else BG_COLOR.
  - Runs H_ACTIVE cycles, then HBLANK.
- HBLANK: `h_sync`=0, `v_sync`=1, `pixel_out`=0, `pixel_x`=0, `pixel_y`=vc.
  - Runs H_BLANK cycles.
  - Then ACTIVE with vc+1, or VBLANK if vc = V_ACTIVE−1.
- VBLANK: `h_sync`=0, `v_sync`=0, `pixel_out`=0, `pixel_x`=`pixel_y`=0; `frame_done`=1 on the first cycle only.
  - Runs V_BLANK cycles.
  - On the last cycle, if `enable`=1: re-latch `box_*`, then next cycle is ACTIVE x=0, y=0 (back-to-back frames). Otherwise IDLE.
- Rectangle parameters are held constant for a whole frame; `box_*` changes mid-frame take effect next frame only.
- Bound arithmetic uses CW+1 bits, so box_x+box_w never wraps.
- Rectangle extending past the frame edge is clipped; a box wholly outside shows no FG pixels. No error flag.
- `enable` dropped mid-frame: the current frame completes, including V blank, then IDLE. No truncated frames.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, latched box 0. Takes effect at the edge `rst` is sampled high, from any state. Mid-frame reset abandons the frame immediately.
- Start latency: `enable` sampled high in IDLE at edge N → first pixel (0,0) on outputs after edge N+1.
- Line period: H_ACTIVE+H_BLANK cycles.
- Frame period: V_ACTIVE·(H_ACTIVE+H_BLANK)+V_BLANK cycles; 130 with defaults.
- Back-to-back: no idle gap between V blank and the next frame's first pixel.
- `rst` and `enable` both high: reset wins.

## Test plan
- Defaults, box (3,3,3,3), `enable` held high → frame of 130 cycles.
  - `h_sync` high in 10 runs of 10 cycles, separated by 2-cycle gaps.
  - `v_sync` high for 120 cycles, then low 10.
  - Exactly 9 FG pixels at x,y∈{3,4,5}; 91 BG pixels.
  - `frame_done` pulses once, 120 cycles after the first pixel.
- Box (8,8,5,5) → FG only at x,y∈{8,9}, i.e. 4 pixels. Box (12,0,3,3) → 0 FG. Box w=0 → 0 FG.
- `box_x` changed from 3 to 6 during line 4 → current frame keeps FG at x 3..5. Next frame has FG at x 6..8.
- `enable` dropped at line 2 → frame completes all 10 lines plus V blank, then IDLE with all outputs 0.
- `rst` asserted during line 5 → outputs 0 the following cycle. With `enable`=1 after release, a fresh frame starts at (0,0) one cycle later.
- `enable` held for 3 frames → 390 cycles, 3 `frame_done` pulses spaced 130 cycles apart, no gaps between frames.
